// File: rtl/bf16_div_seq_if.sv
// Operand/result bundle between the bus side and the bfloat16 divider.
// op_side/bus_side name the two ends; slave/master are aliases of the same views.
interface op_intf #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 7
);
    logic                  op1_sign;
    logic [EXP_WIDTH-1:0]  op1_exp;
    logic [FRAC_WIDTH-1:0] op1_frac;
    logic                  op2_sign;
    logic [EXP_WIDTH-1:0]  op2_exp;
    logic [FRAC_WIDTH-1:0] op2_frac;
    logic                  op3_sign;
    logic [EXP_WIDTH-1:0]  op3_exp;
    logic [FRAC_WIDTH-1:0] op3_frac;
    logic                  overflow;

    modport op_side (
        input  op1_sign, op1_exp, op1_frac, op2_sign, op2_exp, op2_frac,
        output op3_sign, op3_exp, op3_frac, overflow
    );
    modport bus_side (
        output op1_sign, op1_exp, op1_frac, op2_sign, op2_exp, op2_frac,
        input  op3_sign, op3_exp, op3_frac, overflow
    );
    modport slave (
        input  op1_sign, op1_exp, op1_frac, op2_sign, op2_exp, op2_frac,
        output op3_sign, op3_exp, op3_frac, overflow
    );
    modport master (
        output op1_sign, op1_exp, op1_frac, op2_sign, op2_exp, op2_frac,
        input  op3_sign, op3_exp, op3_frac, overflow
    );
endinterface

// File: rtl/bf16_div_seq.sv
// Sequential bfloat16 divider: restoring mantissa division, one quotient bit per
// cycle, fixed latency with start/busy/valid handshake. Truncating, no NaN/inf.
module bf16_div_seq #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 7
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    start_i,
    output logic    busy_o,
    output logic    valid_o,
    op_intf.op_side div_intf
);
    localparam int Q_BITS = FRAC_WIDTH + 2;
    localparam int MW     = FRAC_WIDTH + 1;
    localparam int EW     = EXP_WIDTH + 2;
    localparam int CW     = $clog2(Q_BITS);
    localparam logic [EW-1:0] BIAS         = EW'((1 << (EXP_WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         bitcnt_q, bitcnt_d;
    logic [MW:0]           rem_q, rem_d;
    logic [MW-1:0]         div_q, div_d;
    logic [Q_BITS-1:0]     quo_q, quo_d;
    logic [EXP_WIDTH-1:0]  e1_q, e1_d, e2_q, e2_d;
    logic                  sign_q, sign_d;
    logic                  res_sign_q, res_sign_d;
    logic [EXP_WIDTH-1:0]  res_exp_q, res_exp_d;
    logic [FRAC_WIDTH-1:0] res_frac_q, res_frac_d;
    logic                  ovf_q, ovf_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;

    logic [MW+1:0]         rem_diff;
    logic [EW-1:0]         e_v;
    logic [FRAC_WIDTH-1:0] frac_v;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        rem_d      = rem_q;
        div_d      = div_q;
        quo_d      = quo_q;
        e1_d       = e1_q;
        e2_d       = e2_q;
        sign_d     = sign_q;
        res_sign_d = res_sign_q;
        res_exp_d  = res_exp_q;
        res_frac_d = res_frac_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        rem_diff   = {1'b0, rem_q} - {2'b00, div_q};
        e_v        = '0;
        frac_v     = '0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = CALC;
                    rem_d    = {2'b01, div_intf.op1_frac};
                    div_d    = {1'b1, div_intf.op2_frac};
                    quo_d    = '0;
                    bitcnt_d = CW'(Q_BITS - 1);
                    e1_d     = div_intf.op1_exp;
                    e2_d     = div_intf.op2_exp;
                    sign_d   = div_intf.op1_sign ^ div_intf.op2_sign;
                end
            end
            CALC: begin
                // Negative trial difference means the divisor did not fit: restore.
                if (!rem_diff[MW+1]) begin
                    quo_d = {quo_q[Q_BITS-2:0], 1'b1};
                    rem_d = rem_diff[MW:0] << 1;
                end else begin
                    quo_d = {quo_q[Q_BITS-2:0], 1'b0};
                    rem_d = rem_q << 1;
                end
                bitcnt_d = bitcnt_q - CW'(1);
                if (bitcnt_q == '0) state_d = NORM;
            end
            NORM: begin
                e_v = {2'b00, e1_q} - {2'b00, e2_q} + BIAS;
                if (quo_q[Q_BITS-1]) begin
                    frac_v = quo_q[Q_BITS-2:1];
                end else begin
                    frac_v = quo_q[Q_BITS-3:0];
                    e_v    = e_v - EW'(1);
                end
                res_sign_d = sign_q;
                if (e2_q == '0) begin
                    res_exp_d = '1; res_frac_d = '0; ovf_d = 1'b1;
                end else if (e1_q == '0) begin
                    res_exp_d = '0; res_frac_d = '0; ovf_d = 1'b0;
                end else if ($signed(e_v) >= E_MAX) begin
                    res_exp_d = '1; res_frac_d = '0; ovf_d = 1'b1;
                end else if (e_v[EW-1] || e_v == '0) begin
                    res_exp_d = '0; res_frac_d = '0; ovf_d = 1'b0;
                end else begin
                    res_exp_d = e_v[EXP_WIDTH-1:0]; res_frac_d = frac_v; ovf_d = 1'b0;
                end
                valid_d = 1'b1;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            rem_q      <= '0;
            div_q      <= '0;
            quo_q      <= '0;
            e1_q       <= '0;
            e2_q       <= '0;
            sign_q     <= 1'b0;
            res_sign_q <= 1'b0;
            res_exp_q  <= '0;
            res_frac_q <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            rem_q      <= rem_d;
            div_q      <= div_d;
            quo_q      <= quo_d;
            e1_q       <= e1_d;
            e2_q       <= e2_d;
            sign_q     <= sign_d;
            res_sign_q <= res_sign_d;
            res_exp_q  <= res_exp_d;
            res_frac_q <= res_frac_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    assign busy_o            = busy_q;
    assign valid_o           = valid_q;
    assign div_intf.op3_sign = res_sign_q;
    assign div_intf.op3_exp  = res_exp_q;
    assign div_intf.op3_frac = res_frac_q;
    assign div_intf.overflow = ovf_q;
endmodule
